ysyx_22040931_ex_mem_skid: RTL and testbench

YSYX_22040931_EX_MEM_SKID -- requirements
Module: ysyx_22040931_ex_mem_skid

---
 rtl/ysyx_22040931_ex_mem_skid_pkg.sv | 37 +++
 rtl/ysyx_22040931_PipeSlot.sv | 33 +++
 rtl/ysyx_22040931_ex_mem_skid.sv | 125 ++++++++++++
 tb/tb_ysyx_22040931_ex_mem_skid.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040931_ex_mem_skid_pkg.sv
// ============================================================================
// Module : ysyx_22040931_ex_mem_skid_pkg
// Brief  : Shared widths and mem_op encodings for the EX->MEM skid stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ysyx_22040931_ex_mem_skid_pkg;

  // Datapath widths
  localparam int DATA_BUS = 64;
  localparam int PC_BUS   = 64;
  localparam int RD_W     = 5;
  localparam int MEM_OP_W = 4;

  // mem_op encodings (0 = no memory access)
  localparam logic [MEM_OP_W-1:0] MEM_OP_NONE = 4'd0;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LB   = 4'd1;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LH   = 4'd2;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LW   = 4'd3;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LD   = 4'd4;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LBU  = 4'd5;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LHU  = 4'd6;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LWU  = 4'd7;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SB   = 4'd8;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SH   = 4'd9;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SW   = 4'd10;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SD   = 4'd11;

  // Width of one packed pipeline entry
  function automatic int entry_width(input int data_w, input int pc_w);
    return 2 * data_w + pc_w + RD_W + 1 + MEM_OP_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22040931_PipeSlot.sv
// ============================================================================
// Module : ysyx_22040931_PipeSlot
// Brief  : Resettable register holding one packed pipeline entry.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_22040931_PipeSlot #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] slot_q;

  // Capture the entry when loaded; async reset clears it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
    end else if (load_i) begin
      slot_q <= d_i;
    end
  end

  assign q_o = slot_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_22040931_ex_mem_skid.sv
// ============================================================================
// Module : ysyx_22040931_ex_mem_skid
// Brief  : Two-entry in-order skid buffer between EX and MEM. Handshake
//          outputs are decoded from registered state only.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_22040931_ex_mem_skid
  import ysyx_22040931_ex_mem_skid_pkg::*;
#(
  parameter int DATA_W = DATA_BUS,
  parameter int PC_W   = PC_BUS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_result,
  input  logic [DATA_W-1:0]   in_store_data,
  input  logic [PC_W-1:0]     in_pc,
  input  logic [RD_W-1:0]     in_rd,
  input  logic                in_rd_wen,
  input  logic [MEM_OP_W-1:0] in_mem_op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_result,
  output logic [DATA_W-1:0]   out_store_data,
  output logic [PC_W-1:0]     out_pc,
  output logic [RD_W-1:0]     out_rd,
  output logic                out_rd_wen,
  output logic [MEM_OP_W-1:0] out_mem_op
);

  localparam int ENTRY_W = entry_width(DATA_W, PC_W);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 head_load_d, skid_load_d, head_from_skid_d;
  logic [ENTRY_W-1:0]   w_in_entry, head_d, head_q, skid_q;
  logic                 w_push, w_pop;

  assign w_in_entry = {in_result, in_store_data, in_pc, in_rd, in_rd_wen, in_mem_op};

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and slot load control; flush overrides everything and loads nothing
  always_comb begin
    state_d          = state_q;
    head_load_d      = 1'b0;
    skid_load_d      = 1'b0;
    head_from_skid_d = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (w_push) begin
            state_d     = ST_ONE;
            head_load_d = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            head_load_d = 1'b1;
          end else if (w_push) begin
            state_d     = ST_FULL;
            skid_load_d = 1'b1;
          end else if (w_pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            state_d          = ST_ONE;
            head_load_d      = 1'b1;
            head_from_skid_d = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign head_d = head_from_skid_d ? skid_q : w_in_entry;

  ysyx_22040931_PipeSlot #(.W(ENTRY_W)) u_head (
    .clock  (clock),
    .reset  (reset),
    .load_i (head_load_d),
    .d_i    (head_d),
    .q_o    (head_q)
  );

  ysyx_22040931_PipeSlot #(.W(ENTRY_W)) u_skid (
    .clock  (clock),
    .reset  (reset),
    .load_i (skid_load_d),
    .d_i    (w_in_entry),
    .q_o    (skid_q)
  );

  assign {out_result, out_store_data, out_pc, out_rd, out_rd_wen, out_mem_op} = head_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040931_ex_mem_skid.sv
// ============================================================================
// Module : tb_ysyx_22040931_ex_mem_skid
// Brief  : Directed self-checking bench for the EX->MEM skid buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22040931_ex_mem_skid;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_result;
  logic [63:0] in_store_data;
  logic [63:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [3:0]  in_mem_op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [63:0] out_store_data;
  logic [63:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [3:0]  out_mem_op;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  ysyx_22040931_ex_mem_skid #(.DATA_W(64), .PC_W(64)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_result      (in_result),
    .in_store_data  (in_store_data),
    .in_pc          (in_pc),
    .in_rd          (in_rd),
    .in_rd_wen      (in_rd_wen),
    .in_mem_op      (in_mem_op),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_store_data (out_store_data),
    .out_pc         (out_pc),
    .out_rd         (out_rd),
    .out_rd_wen     (out_rd_wen),
    .out_mem_op     (out_mem_op)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] res);
    in_valid      = v;
    in_result     = res;
    in_store_data = ~res;
    in_pc         = 64'h8000_0000 + res;
    in_rd         = res[4:0];
    in_rd_wen     = v;
    in_mem_op     = res[3:0];
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 64'h0);
    step();
    step();

    // Reset then idle
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_result",    out_result,         64'd0);
    chk("rst_pc",        out_pc,             64'd0);
    reset = 1'b0;

    // Single push, accepted on the first edge after reset release
    drive(1'b1, 64'h1234);
    in_rd     = 5'd5;
    out_ready = 1'b1;
    step();
    drive(1'b0, 64'h0);
    chk("single_valid",  {63'd0, out_valid}, 64'd1);
    chk("single_result", out_result,         64'h1234);
    chk("single_rd",     {59'd0, out_rd},    64'd5);
    chk("single_sdata",  out_store_data,     ~64'h1234);
    chk("single_pc",     out_pc,             64'h8000_1234);
    step();
    chk("single_drain",  {63'd0, out_valid}, 64'd0);

    // Backpressure: fill both slots
    out_ready = 1'b0;
    drive(1'b1, 64'h11);
    step();
    drive(1'b1, 64'h22);
    step();
    drive(1'b0, 64'h0);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_head",     out_result,        64'h11);
    step();
    chk("bp_hold",     out_result,        64'h11);
    chk("bp_hold_pc",  out_pc,            64'h8000_0011);
    out_ready = 1'b1;
    chk("bp_pop_a",    out_result,        64'h11);
    step();
    chk("bp_pop_b_v",  {63'd0, out_valid}, 64'd1);
    chk("bp_pop_b",    out_result,         64'h22);
    chk("bp_pop_b_rd", {59'd0, out_rd},    64'h2);
    step();
    chk("bp_empty_v",  {63'd0, out_valid}, 64'd0);
    chk("bp_empty_r",  {63'd0, in_ready},  64'd1);

    // Streaming at full throughput
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 64'(i));
      step();
      chk("stream_valid", {63'd0, out_valid}, 64'd1);
      chk("stream_data",  out_result,         64'(i));
      chk("stream_ready", {63'd0, in_ready},  64'd1);
    end
    drive(1'b0, 64'h0);
    step();
    chk("stream_end", {63'd0, out_valid}, 64'd0);

    // Flush while FULL with a new entry presented
    out_ready = 1'b0;
    drive(1'b1, 64'h55);
    step();
    drive(1'b1, 64'h66);
    step();
    chk("fl_full", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 64'h99);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 64'h0);
    chk("fl_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_ready", {63'd0, in_ready},  64'd1);
    chk("fl_keep",  out_result,         64'h55);
    out_ready = 1'b1;
    step();
    chk("fl_no99_v", {63'd0, out_valid}, 64'd0);
    chk("fl_no99_d", out_result,         64'h55);

    // Flush while ONE with a push: the pushed entry is dropped
    drive(1'b1, 64'h70);
    step();
    chk("fl1_one", out_result, 64'h70);
    drive(1'b1, 64'h77);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 64'h0);
    chk("fl1_valid", {63'd0, out_valid}, 64'd0);
    chk("fl1_data",  out_result,         64'h70);

    // Async reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 64'hA1);
    step();
    drive(1'b1, 64'hA2);
    step();
    drive(1'b0, 64'h0);
    chk("ar_full", {63'd0, in_ready}, 64'd0);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_valid_async", {63'd0, out_valid}, 64'd0);
    chk("ar_ready_async", {63'd0, in_ready},  64'd1);
    chk("ar_data_async",  out_result,         64'd0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    chk("ar_empty", {63'd0, out_valid}, 64'd0);
    step();
    chk("ar_no_skid", {63'd0, out_valid}, 64'd0);

    // First push after reset release is accepted immediately
    drive(1'b1, 64'hB0);
    step();
    drive(1'b0, 64'h0);
    chk("ar_push_v", {63'd0, out_valid}, 64'd1);
    chk("ar_push_d", out_result,         64'hB0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
